// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: valid/ready handshake, freeze, flush and a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to build the saturating stall/bubble performance counters.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              freeze,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high.
    // in_ready depends only on flops, freeze and flush, never on out_ready.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        HALF  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state, state_n;
    logic [CTRL_W-1:0] main_ctrl, main_ctrl_n, skid_ctrl, skid_ctrl_n;
    logic [DATA_W-1:0] main_data, main_data_n, skid_data, skid_data_n;
    logic              main_valid, skid_valid;
    logic              accept, pop;

    assign main_valid = (state != EMPTY);
    assign skid_valid = (state == FULL);

    assign in_ready  = ~skid_valid & ~freeze & ~flush;
    assign accept    = in_valid & in_ready;
    assign pop       = main_valid & out_ready & ~freeze & ~flush;

    assign out_valid = main_valid;
    assign out_ctrl  = main_valid ? main_ctrl : '0;
    assign out_data  = main_data;
    assign occupancy = state;

    always_comb begin
        state_n     = state;
        main_ctrl_n = main_ctrl;
        main_data_n = main_data;
        skid_ctrl_n = skid_ctrl;
        skid_data_n = skid_data;
        if (flush) begin
            state_n     = EMPTY;
            main_ctrl_n = '0;
            skid_ctrl_n = '0;
        end else begin
            // freeze forces accept and pop low, so every branch below holds.
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_n     = HALF;
                        main_ctrl_n = in_ctrl;
                        main_data_n = in_data;
                    end
                end
                HALF: begin
                    if (accept && pop) begin
                        main_ctrl_n = in_ctrl;
                        main_data_n = in_data;
                    end else if (accept) begin
                        state_n     = FULL;
                        skid_ctrl_n = in_ctrl;
                        skid_data_n = in_data;
                    end else if (pop) begin
                        state_n     = EMPTY;
                        main_ctrl_n = '0;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_n     = HALF;
                        main_ctrl_n = skid_ctrl;
                        main_data_n = skid_data;
                        skid_ctrl_n = '0;
                    end
                end
                default: begin
                    state_n     = EMPTY;
                    main_ctrl_n = '0;
                    skid_ctrl_n = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            state     <= state_n;
            main_ctrl <= main_ctrl_n;
            main_data <= main_data_n;
            skid_ctrl <= skid_ctrl_n;
            skid_data <= skid_data_n;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q;

    // Counters keep running through freeze and flush; only rst clears them.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            if (main_valid && !pop && (stall_q != '1))
                stall_q <= stall_q + 1'b1;
            if (!main_valid && (bubble_q != '1))
                bubble_q <= bubble_q + 1'b1;
        end
    end

    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;
`else
    assign stall_cnt  = '0;
    assign bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf: reset, streaming, skid, freeze, flush, counters.
module tb_pipe_stage_buf;

    localparam int DATA_W = 32;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst, flush, freeze;
    logic              in_valid, in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              out_valid, out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt, bubble_cnt;

    int errors = 0;
    int checks = 0;

    pipe_stage_buf #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze),
        .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_data(out_data),
        .occupancy(occupancy), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 clk = ~clk;

    // Inputs change 1ns after the rising edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        in_valid = v;
        in_ctrl  = c;
        in_data  = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; out_ready = 1'b0;
        drive(1'b1, 8'hFF, 32'hDEAD_BEEF);
        tick();
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
        checks++; if (out_ctrl !== 8'h00) begin errors++; $display("FAIL reset_ctrl got=%h exp=00", out_ctrl); end
        checks++; if (out_data !== 32'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", out_data); end
        checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
        checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, bubble_cnt); end
        rst = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'(i + 1), 32'(32'h11 + i));
            #1;
            checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d] got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'(32'h11 + i) || out_ctrl !== 8'(i + 1)) begin
                errors++; $display("FAIL b2b_out[%0d] got v=%0b d=%h c=%h exp v=1 d=%h c=%h", i, out_valid, out_data, out_ctrl, 32'h11 + i, i + 1);
            end
            checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL b2b_occ[%0d] got=%0d exp=1", i, occupancy); end
        end
        drive(1'b0, 8'h00, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0) begin
            errors++; $display("FAIL b2b_drain got v=%0b c=%h occ=%0d exp 0/00/0", out_valid, out_ctrl, occupancy);
        end
    endtask

    task automatic test_skid();
        out_ready = 1'b0;
        drive(1'b1, 8'h0A, 32'hAAAA_0001);
        tick();
        checks++; if (occupancy !== 2'd1 || out_data !== 32'hAAAA_0001) begin errors++; $display("FAIL skid_a got occ=%0d d=%h exp 1/AAAA0001", occupancy, out_data); end
        drive(1'b1, 8'h0B, 32'hBBBB_0002);
        tick();
        drive(1'b1, 8'h0C, 32'hCCCC_0003);
        #1;
        checks++; if (occupancy !== 2'd2 || in_ready !== 1'b0) begin errors++; $display("FAIL skid_full got occ=%0d rdy=%0b exp 2/0", occupancy, in_ready); end
        tick();
        checks++; if (occupancy !== 2'd2 || out_data !== 32'hAAAA_0001 || out_ctrl !== 8'h0A) begin
            errors++; $display("FAIL skid_hold got occ=%0d d=%h c=%h exp 2/AAAA0001/0A", occupancy, out_data, out_ctrl);
        end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hBBBB_0002 || out_ctrl !== 8'h0B || occupancy !== 2'd1) begin
            errors++; $display("FAIL skid_b got v=%0b d=%h c=%h occ=%0d exp 1/BBBB0002/0B/1", out_valid, out_data, out_ctrl, occupancy);
        end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL skid_refill_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 32'hCCCC_0003 || out_ctrl !== 8'h0C) begin
            errors++; $display("FAIL skid_c got v=%0b d=%h c=%h exp 1/CCCC0003/0C", out_valid, out_data, out_ctrl);
        end
        drive(1'b0, 8'h00, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL skid_drain got v=%0b occ=%0d exp 0/0", out_valid, occupancy); end
    endtask

    task automatic test_freeze();
        out_ready = 1'b0;
        drive(1'b1, 8'h5A, 32'h0000_00DD);
        tick();
        freeze = 1'b1; out_ready = 1'b1;
        drive(1'b1, 8'h3C, 32'h0000_00EE);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL freeze_in_ready got=%0b exp=0", in_ready); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b1 || out_data !== 32'h0000_00DD || out_ctrl !== 8'h5A || occupancy !== 2'd1) begin
                errors++; $display("FAIL freeze_hold[%0d] got v=%0b d=%h c=%h occ=%0d exp 1/DD/5A/1", i, out_valid, out_data, out_ctrl, occupancy);
            end
        end
        freeze = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unfreeze_ready got=%0b exp=1", in_ready); end
        tick();
        checks++; if (out_data !== 32'h0000_00EE || out_ctrl !== 8'h3C || occupancy !== 2'd1) begin
            errors++; $display("FAIL unfreeze_next got d=%h c=%h occ=%0d exp EE/3C/1", out_data, out_ctrl, occupancy);
        end
        drive(1'b0, 8'h00, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL freeze_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 8'h21, 32'hF100_0001);
        tick();
        drive(1'b1, 8'h22, 32'hF200_0002);
        tick();
        checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL flush_setup_occ got=%0d exp=2", occupancy); end
        freeze = 1'b1; flush = 1'b1;
        drive(1'b1, 8'h99, 32'h0000_0099);
        tick();
        flush = 1'b0; freeze = 1'b0;
        drive(1'b0, 8'h00, 32'h0);
        #1;
        checks++; if (out_valid !== 1'b0 || out_ctrl !== 8'h00 || occupancy !== 2'd0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_empty got v=%0b c=%h occ=%0d rdy=%0b exp 0/00/0/1", out_valid, out_ctrl, occupancy, in_ready);
        end
        checks++; if (out_data !== 32'hF100_0001) begin errors++; $display("FAIL flush_data_hold got=%h exp=F1000001", out_data); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_dropped[%0d] got v=%0b d=%h exp v=0", i, out_valid, out_data); end
        end
    endtask

    task automatic test_counters();
        logic [CNT_W-1:0] exp_stall, exp_bubble;
`ifdef PIPE_STAGE_PERF_EN
        exp_stall  = 4'd15;
        exp_bubble = 4'd1;
`else
        exp_stall  = 4'd0;
        exp_bubble = 4'd0;
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0; out_ready = 1'b0;
        drive(1'b1, 8'h01, 32'h0000_0C01);
        tick();
        drive(1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 20; i++) tick();
        checks++; if (stall_cnt !== exp_stall || bubble_cnt !== exp_bubble) begin
            errors++; $display("FAIL cnt_saturate got stall=%0d bubble=%0d exp %0d/%0d", stall_cnt, bubble_cnt, exp_stall, exp_bubble);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++; if (stall_cnt !== exp_stall || occupancy !== 2'd0) begin
            errors++; $display("FAIL cnt_after_flush got stall=%0d occ=%0d exp %0d/0", stall_cnt, occupancy, exp_stall);
        end
        drive(1'b1, 8'h41, 32'h4100_0001);
        tick();
        drive(1'b1, 8'h42, 32'h4200_0002);
        tick();
        drive(1'b0, 8'h00, 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin
            errors++; $display("FAIL rst_while_full got occ=%0d v=%0b d=%h exp 0/0/0", occupancy, out_valid, out_data);
        end
        checks++; if (stall_cnt !== 4'd0 || bubble_cnt !== 4'd0) begin
            errors++; $display("FAIL cnt_after_rst got stall=%0d bubble=%0d exp 0/0", stall_cnt, bubble_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_skid();
        test_freeze();
        test_flush();
        test_counters();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
